// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl: parses 5-byte command frames from the UART receiver
// into host register writes; flags bad checksums and inter-byte stalls.
module uart_rx_cmd_ctrl #(
  parameter logic [7:0] HEADER      = 8'h55,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         CNT_W       = 16
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Rx_Done,
  input  logic [7:0]  Rx_Data,
  output logic        m_wr,
  output logic [7:0]  m_addr,
  output logic [15:0] m_wrdata,
  output logic        Frame_Err
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATH,
    DATL,
    CHK
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        dh_q, dh_d;
  logic [7:0]        dl_q, dl_d;
  logic [7:0]        sum_q, sum_d;
  logic              wr_q, wr_d;
  logic [7:0]        maddr_q, maddr_d;
  logic [15:0]       mdata_q, mdata_d;
  logic              err_q, err_d;
  logic              timeout;

  // Frame parser, stall timer and registered host outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    addr_d  = addr_q;
    dh_d    = dh_q;
    dl_d    = dl_q;
    sum_d   = sum_q;
    wr_d    = 1'b0;
    err_d   = 1'b0;
    maddr_d = maddr_q;
    mdata_d = mdata_q;

    if (Rx_Done || state_q == IDLE) begin
      cnt_d = '0;
    end

    timeout = (state_q != IDLE) && !Rx_Done &&
              (cnt_q == TO_LAST);

    case (state_q)
      IDLE: begin
        if (Rx_Done && Rx_Data == HEADER) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (Rx_Done) begin
          addr_d  = Rx_Data;
          sum_d   = Rx_Data;
          state_d = DATH;
        end
      end
      DATH: begin
        if (Rx_Done) begin
          dh_d    = Rx_Data;
          sum_d   = sum_q + Rx_Data;
          state_d = DATL;
        end
      end
      DATL: begin
        if (Rx_Done) begin
          dl_d    = Rx_Data;
          sum_d   = sum_q + Rx_Data;
          state_d = CHK;
        end
      end
      CHK: begin
        if (Rx_Done) begin
          state_d = IDLE;
          if (Rx_Data == sum_q) begin
            wr_d    = 1'b1;
            maddr_d = addr_q;
            mdata_d = {dh_q, dl_q};
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
      cnt_d   = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dh_q    <= '0;
      dl_q    <= '0;
      sum_q   <= '0;
      wr_q    <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dh_q    <= dh_d;
      dl_q    <= dl_d;
      sum_q   <= sum_d;
      wr_q    <= wr_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      err_q   <= err_d;
    end
  end

  assign m_wr      = wr_q;
  assign m_addr    = maddr_q;
  assign m_wrdata  = mdata_q;
  assign Frame_Err = err_q;

endmodule
